// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES streaming controller slice.
package aes_stream_pkg;

    localparam int DATA_W = 128;
    localparam int KEY_W  = 256;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEY_LO = 3'd1,
        KEY_HI = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    // Blocks may be issued to the core only while streaming or draining.
    function automatic logic issue_phase(input state_e s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with fill count.
// A push on full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int             AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  A_ONE  = AW'(1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);
    localparam logic [CW-1:0]  C_ZERO = CW'(0);
    localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against current occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != C_ZERO);
        do_push_s = push && ((count_r != C_FULL) || do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= C_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + A_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + A_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + C_ONE;
                2'b01:   count_r <= count_r - C_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign empty    = (count_r == C_ZERO);
    assign count    = count_r;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streaming controller for the pipelined AES-256 core: key load, credit-based
// block issue with a minimum issue interval, and buffered result delivery.
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int ISSUE_GAP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic              mode,
    input  logic              stop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              ready_for_inp,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              ready_to_out,
    output logic [DATA_W-1:0] core_data,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_key_valid,
    output logic              core_mode,
    output logic              core_start,
    input  logic [DATA_W-1:0] core_result,
    input  logic              core_result_valid,
    output logic              done,
    output logic              err,
    output logic [31:0]       blk_count,
    output logic [2:0]        state
);
    localparam int                IN_CW      = $clog2(IN_DEPTH + 1);
    localparam int                OUT_CW     = $clog2(OUT_DEPTH + 1);
    localparam int                GAP_W      = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [IN_CW-1:0]  IN_LIM     = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW:0]   CREDIT_LIM = (OUT_CW + 1)'(OUT_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_ZERO   = OUT_CW'(0);
    localparam logic [OUT_CW-1:0] OUT_ONE    = OUT_CW'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ZERO   = GAP_W'(0);
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [KEY_W-1:0]    key_r;
    logic                key_valid_r;
    logic                mode_r;
    logic [DATA_W-1:0]   core_data_r;
    logic                core_start_r;
    logic [GAP_W-1:0]    gap_r;
    logic [OUT_CW-1:0]   outstanding_r;
    logic                err_r;
    logic                done_r;
    logic [31:0]         blk_count_r;

    logic                ready_s;
    logic                in_push_s;
    logic                in_empty_s;
    logic [IN_CW-1:0]    in_count_s;
    logic [DATA_W-1:0]   in_head_s;
    logic                out_empty_s;
    logic [OUT_CW-1:0]   out_count_s;
    logic                out_pop_s;
    logic                ret_ok_s;
    logic                credit_s;
    logic                issue_s;
    logic                drain_done_s;

    // Handshake, credit and issue decode from registered state.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            KEY_LO, KEY_HI: ready_s = 1'b1;
            RUN:            ready_s = (in_count_s < IN_LIM);
            default:        ready_s = 1'b0;
        endcase
        in_push_s    = in_valid && ready_s && (state_r == RUN);
        ret_ok_s     = core_result_valid && (outstanding_r != OUT_ZERO);
        credit_s     = (({1'b0, outstanding_r} + {1'b0, out_count_s}) < CREDIT_LIM);
        issue_s      = issue_phase(state_r) && !in_empty_s && (gap_r == GAP_ZERO) && credit_s;
        out_pop_s    = !out_empty_s && ready_to_out;
        drain_done_s = in_empty_s && (outstanding_r == OUT_ZERO) && out_empty_s;
    end

    // Next-state logic for the stream sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (key_load) state_nxt_s = KEY_LO; else state_nxt_s = IDLE;
            KEY_LO:  if (in_valid) state_nxt_s = KEY_HI; else state_nxt_s = KEY_LO;
            KEY_HI:  if (in_valid) state_nxt_s = RUN;    else state_nxt_s = KEY_HI;
            RUN:     if (stop)     state_nxt_s = DRAIN;  else state_nxt_s = RUN;
            DRAIN:   if (drain_done_s) state_nxt_s = IDLE; else state_nxt_s = DRAIN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Key/mode latching, issue pacing, credit tracking and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r         <= {KEY_W{1'b0}};
            key_valid_r   <= 1'b0;
            mode_r        <= MODE_ENC;
            core_data_r   <= {DATA_W{1'b0}};
            core_start_r  <= 1'b0;
            gap_r         <= GAP_ZERO;
            outstanding_r <= OUT_ZERO;
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            blk_count_r   <= 32'd0;
        end else begin
            core_start_r <= issue_s;
            done_r       <= (state_r == DRAIN) && drain_done_s;
            if ((state_r == IDLE) && key_load) begin
                mode_r      <= mode;
                key_valid_r <= 1'b0;
            end
            if ((state_r == KEY_LO) && in_valid) begin
                key_r[KEY_W-1:DATA_W] <= in_data;
            end
            if ((state_r == KEY_HI) && in_valid) begin
                key_r[DATA_W-1:0] <= in_data;
                key_valid_r       <= 1'b1;
            end
            if (issue_s) begin
                core_data_r <= in_head_s;
                gap_r       <= GAP_LOAD;
            end else if (gap_r != GAP_ZERO) begin
                gap_r <= gap_r - GAP_ONE;
            end
            case ({issue_s, ret_ok_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
                2'b01:   outstanding_r <= outstanding_r - OUT_ONE;
                default: outstanding_r <= outstanding_r;
            endcase
            // A result nobody asked for is dropped and flagged permanently.
            if (core_result_valid && (outstanding_r == OUT_ZERO)) begin
                err_r <= 1'b1;
            end
            if (out_pop_s) begin
                blk_count_r <= blk_count_r + 32'd1;
            end
        end
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_push_s),
        .push_data (in_data),
        .pop       (issue_s),
        .pop_data  (in_head_s),
        .empty     (in_empty_s),
        .count     (in_count_s)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret_ok_s),
        .push_data (core_result),
        .pop       (out_pop_s),
        .pop_data  (out_data),
        .empty     (out_empty_s),
        .count     (out_count_s)
    );

    assign ready_for_inp  = ready_s;
    assign out_valid      = !out_empty_s;
    assign core_data      = core_data_r;
    assign core_key       = key_r;
    assign core_key_valid = key_valid_r;
    assign core_mode      = mode_r;
    assign core_start     = core_start_r;
    assign done           = done_r;
    assign err            = err_r;
    assign blk_count      = blk_count_r;
    assign state          = state_r;

endmodule
